// File: rtl/cmd_rt_pkg.sv
// Shared types and constants for the real-time command queue.
// A command is the full set of burst parameters in host word-map order.
package cmd_rt_pkg;

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] delta_freq;
        logic [31:0] delta_rate;
        logic [63:0] time_start;
        logic [15:0] n_impuls;
        logic [1:0]  imp_type;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tblank1;
        logic [31:0] tblank2;
    } cmd_t;

    localparam logic [3:0] W_FREQ_LO   = 4'd0;
    localparam logic [3:0] W_FREQ_HI   = 4'd1;
    localparam logic [3:0] W_DFREQ_LO  = 4'd2;
    localparam logic [3:0] W_DFREQ_HI  = 4'd3;
    localparam logic [3:0] W_DRATE     = 4'd4;
    localparam logic [3:0] W_TSTART_LO = 4'd5;
    localparam logic [3:0] W_TSTART_HI = 4'd6;
    localparam logic [3:0] W_NTYPE     = 4'd7;
    localparam logic [3:0] W_TI        = 4'd8;
    localparam logic [3:0] W_TP        = 4'd9;
    localparam logic [3:0] W_TBLANK1   = 4'd10;
    localparam logic [3:0] W_TBLANK2   = 4'd11;

    typedef enum logic [1:0] {IDLE, READ, CHECK, WAIT} state_t;

    // Plain unsigned compare; a TIME close to wrap-around is not handled.
    function automatic logic time_ok(input logic [63:0] ts, input logic [63:0] now,
                                     input logic [63:0] lead);
        return ts >= now + lead;
    endfunction

endpackage

// File: rtl/cmd_fifo_sync.sv
// Single-clock FIFO of commands with a registered read port.
// Read data updates on the pop edge; a simultaneous push is accepted when full.
module cmd_fifo_sync
    import cmd_rt_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  cmd_t                     wdata_i,
    input  logic                     pop_i,
    output cmd_t                     rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    cmd_t          mem_q [DEPTH];
    cmd_t          rdata_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                rdata_q  <= mem_q[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rdata_o = rdata_q;
    assign level_o = cnt_q;

endmodule

// File: rtl/cmd_rt_queue.sv
// Real-time command queue: stages host words, queues committed commands and
// hands them to the burst sequencer one at a time, dropping late ones.
module cmd_rt_queue
    import cmd_rt_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned LEAD_TICKS = 64
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   HOST_WE,
    input  logic [3:0]             HOST_ADDR,
    input  logic [31:0]            HOST_WDATA,
    input  logic                   FLUSH,
    input  logic [63:0]            TIME,
    input  logic                   SYS_TIME_UPDATE_OK,
    input  logic                   REQ_COMMAND,
    output logic                   WR_DATA,
    output logic [47:0]            MEM_DDS_freq,
    output logic [47:0]            MEM_DDS_delta_freq,
    output logic [31:0]            MEM_DDS_delta_rate,
    output logic [63:0]            MEM_TIME_START,
    output logic [15:0]            MEM_N_impuls,
    output logic [1:0]             MEM_TYPE_impulse,
    output logic [31:0]            MEM_Interval_Ti,
    output logic [31:0]            MEM_Interval_Tp,
    output logic [31:0]            MEM_Tblank1,
    output logic [31:0]            MEM_Tblank2,
    output logic [$clog2(DEPTH):0] LEVEL,
    output logic                   FULL,
    output logic                   EMPTY,
    output logic                   OVERFLOW,
    output logic                   DROP,
    output logic [15:0]            DROP_CNT,
    output logic                   LOADED
);

    cmd_t        stage_q, stage_d, fifo_rdata, mem_q;
    state_t      state_q;
    logic        wr_data_q, loaded_q, drop_q, overflow_q, req_prev_q;
    logic [15:0] drop_cnt_q;
    logic        commit, pop, acc;

    assign commit = HOST_WE && (HOST_ADDR == W_TBLANK2);
    assign acc    = REQ_COMMAND & ~req_prev_q;
    assign pop    = (state_q == IDLE) && !loaded_q && !EMPTY && !FLUSH;

    always_comb begin
        stage_d = stage_q;
        if (HOST_WE) begin
            case (HOST_ADDR)
                W_FREQ_LO:   stage_d.freq[31:0]        = HOST_WDATA;
                W_FREQ_HI:   stage_d.freq[47:32]       = HOST_WDATA[15:0];
                W_DFREQ_LO:  stage_d.delta_freq[31:0]  = HOST_WDATA;
                W_DFREQ_HI:  stage_d.delta_freq[47:32] = HOST_WDATA[15:0];
                W_DRATE:     stage_d.delta_rate        = HOST_WDATA;
                W_TSTART_LO: stage_d.time_start[31:0]  = HOST_WDATA;
                W_TSTART_HI: stage_d.time_start[63:32] = HOST_WDATA;
                W_NTYPE: begin
                    stage_d.n_impuls = HOST_WDATA[15:0];
                    stage_d.imp_type = HOST_WDATA[17:16];
                end
                W_TI:        stage_d.ti      = HOST_WDATA;
                W_TP:        stage_d.tp      = HOST_WDATA;
                W_TBLANK1:   stage_d.tblank1 = HOST_WDATA;
                W_TBLANK2:   stage_d.tblank2 = HOST_WDATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)      stage_q <= '0;
        else if (FLUSH) stage_q <= '0;
        else            stage_q <= stage_d;
    end

    cmd_fifo_sync #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .clr_i   (FLUSH),
        .push_i  (commit),
        .wdata_i (stage_d),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .level_o (LEVEL),
        .full_o  (FULL),
        .empty_o (EMPTY)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            wr_data_q  <= 1'b0;
            loaded_q   <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
            req_prev_q <= 1'b0;
            mem_q      <= '1;
        end else begin
            req_prev_q <= REQ_COMMAND;
            wr_data_q  <= 1'b0;
            drop_q     <= 1'b0;
            if (FLUSH) begin
                state_q    <= IDLE;
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
                // A loaded command is neutralised by reloading it with an unreachable start time.
                if (loaded_q) begin
                    wr_data_q           <= 1'b1;
                    mem_q.time_start    <= '1;
                    loaded_q            <= 1'b0;
                end
            end else begin
                if (commit && FULL && !pop) overflow_q <= 1'b1;
                case (state_q)
                    IDLE:  if (pop) state_q <= READ;
                    READ:  state_q <= CHECK;
                    CHECK: if (SYS_TIME_UPDATE_OK) begin
                        if (time_ok(fifo_rdata.time_start, TIME, 64'(LEAD_TICKS))) begin
                            mem_q     <= fifo_rdata;
                            wr_data_q <= 1'b1;
                            loaded_q  <= 1'b1;
                            state_q   <= WAIT;
                        end else begin
                            drop_q <= 1'b1;
                            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    WAIT: if (acc) begin
                        loaded_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign WR_DATA            = wr_data_q;
    assign LOADED             = loaded_q;
    assign DROP               = drop_q;
    assign DROP_CNT           = drop_cnt_q;
    assign OVERFLOW           = overflow_q;
    assign MEM_DDS_freq       = mem_q.freq;
    assign MEM_DDS_delta_freq = mem_q.delta_freq;
    assign MEM_DDS_delta_rate = mem_q.delta_rate;
    assign MEM_TIME_START     = mem_q.time_start;
    assign MEM_N_impuls       = mem_q.n_impuls;
    assign MEM_TYPE_impulse   = mem_q.imp_type;
    assign MEM_Interval_Ti    = mem_q.ti;
    assign MEM_Interval_Tp    = mem_q.tp;
    assign MEM_Tblank1        = mem_q.tblank1;
    assign MEM_Tblank2        = mem_q.tblank2;

endmodule

// File: tb/tb_cmd_rt_queue.sv
// Directed bench for cmd_rt_queue: latency, ordering, drops, overflow,
// flush, time-sync gating and asynchronous reset.
module tb_cmd_rt_queue;
    import cmd_rt_pkg::*;

    localparam logic [63:0] T0   = 64'h0000_0001_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        CLK, RESET, HOST_WE, FLUSH, SYS_TIME_UPDATE_OK, REQ_COMMAND;
    logic [3:0]  HOST_ADDR;
    logic [31:0] HOST_WDATA;
    logic [63:0] TIME;
    logic        WR_DATA, FULL, EMPTY, OVERFLOW, DROP, LOADED;
    logic [47:0] MEM_DDS_freq, MEM_DDS_delta_freq;
    logic [31:0] MEM_DDS_delta_rate, MEM_Interval_Ti, MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2;
    logic [63:0] MEM_TIME_START;
    logic [15:0] MEM_N_impuls, DROP_CNT;
    logic [1:0]  MEM_TYPE_impulse;
    logic [4:0]  LEVEL;

    int n_chk  = 0;
    int n_fail = 0;

    cmd_rt_queue #(.DEPTH(16), .LEAD_TICKS(64)) dut (
        .CLK(CLK), .RESET(RESET), .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR),
        .HOST_WDATA(HOST_WDATA), .FLUSH(FLUSH), .TIME(TIME),
        .SYS_TIME_UPDATE_OK(SYS_TIME_UPDATE_OK), .REQ_COMMAND(REQ_COMMAND),
        .WR_DATA(WR_DATA), .MEM_DDS_freq(MEM_DDS_freq), .MEM_DDS_delta_freq(MEM_DDS_delta_freq),
        .MEM_DDS_delta_rate(MEM_DDS_delta_rate), .MEM_TIME_START(MEM_TIME_START),
        .MEM_N_impuls(MEM_N_impuls), .MEM_TYPE_impulse(MEM_TYPE_impulse),
        .MEM_Interval_Ti(MEM_Interval_Ti), .MEM_Interval_Tp(MEM_Interval_Tp),
        .MEM_Tblank1(MEM_Tblank1), .MEM_Tblank2(MEM_Tblank2), .LEVEL(LEVEL),
        .FULL(FULL), .EMPTY(EMPTY), .OVERFLOW(OVERFLOW), .DROP(DROP),
        .DROP_CNT(DROP_CNT), .LOADED(LOADED)
    );

    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [31:0] d);
        HOST_ADDR  = a;
        HOST_WDATA = d;
        HOST_WE    = 1'b1;
        tick();
        HOST_WE    = 1'b0;
    endtask

    function automatic cmd_t mk_cmd(input logic [63:0] ts, input logic [15:0] n,
                                    input logic [31:0] ti, input logic [31:0] b2);
        cmd_t c;
        c.freq       = 48'h1234_5678_9ABC + {32'h0, n};
        c.delta_freq = 48'hABCD_0000_1111 ^ {32'h0, n};
        c.delta_rate = 32'hDEAD_BEEF;
        c.time_start = ts;
        c.n_impuls   = n;
        c.imp_type   = n[1:0] ^ 2'b10;
        c.ti         = ti;
        c.tp         = ti << 1;
        c.tblank1    = b2 + 32'd5;
        c.tblank2    = b2;
        return c;
    endfunction

    // Upper bits of the split and packed words carry junk the DUT must ignore.
    task automatic write_cmd(input cmd_t c);
        host_wr(4'd0,  c.freq[31:0]);
        host_wr(4'd1,  {16'hA5A5, c.freq[47:32]});
        host_wr(4'd2,  c.delta_freq[31:0]);
        host_wr(4'd3,  {16'h5A5A, c.delta_freq[47:32]});
        host_wr(4'd4,  c.delta_rate);
        host_wr(4'd5,  c.time_start[31:0]);
        host_wr(4'd6,  c.time_start[63:32]);
        host_wr(4'd7,  {14'h3FFF, c.imp_type, c.n_impuls});
        host_wr(4'd8,  c.ti);
        host_wr(4'd9,  c.tp);
        host_wr(4'd10, c.tblank1);
        host_wr(4'd11, c.tblank2);
    endtask

    task automatic check_mem(input string tag, input cmd_t c);
        check_eq({tag, " freq"},   MEM_DDS_freq,       c.freq);
        check_eq({tag, " dfreq"},  MEM_DDS_delta_freq, c.delta_freq);
        check_eq({tag, " drate"},  MEM_DDS_delta_rate, c.delta_rate);
        check_eq({tag, " tstart"}, MEM_TIME_START,     c.time_start);
        check_eq({tag, " n"},      MEM_N_impuls,       c.n_impuls);
        check_eq({tag, " type"},   MEM_TYPE_impulse,   c.imp_type);
        check_eq({tag, " ti"},     MEM_Interval_Ti,    c.ti);
        check_eq({tag, " tp"},     MEM_Interval_Tp,    c.tp);
        check_eq({tag, " tb1"},    MEM_Tblank1,        c.tblank1);
        check_eq({tag, " tb2"},    MEM_Tblank2,        c.tblank2);
    endtask

    // Called one step after the commit edge; the load strobe belongs on the third edge after it.
    task automatic expect_issue(input string tag, input cmd_t c);
        tick(); check_eq({tag, " wr@1"}, WR_DATA, 1'b0);
        tick(); check_eq({tag, " wr@2"}, WR_DATA, 1'b0);
        tick(); check_eq({tag, " wr@3"}, WR_DATA, 1'b1);
        check_mem(tag, c);
        check_eq({tag, " loaded"}, LOADED, 1'b1);
        tick(); check_eq({tag, " wr one-cycle"}, WR_DATA, 1'b0);
    endtask

    // REQ_COMMAND high for 20 cycles then low for 20; reports strobes seen and when.
    task automatic req_pulse(output int cnt, output int first, output logic [31:0] b2);
        cnt = 0; first = 0; b2 = '0;
        REQ_COMMAND = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 21) REQ_COMMAND = 1'b0;
            tick();
            if (WR_DATA) begin
                cnt++;
                if (first == 0) begin
                    first = i;
                    b2    = MEM_Tblank2;
                end
            end
        end
    endtask

    initial begin
        cmd_t        a, e, f, h, ic;
        cmd_t        q[3];
        int          cnt, first;
        logic [31:0] b2;

        RESET = 1'b1; HOST_WE = 1'b0; HOST_ADDR = '0; HOST_WDATA = '0; FLUSH = 1'b0;
        TIME = T0; SYS_TIME_UPDATE_OK = 1'b1; REQ_COMMAND = 1'b0;
        repeat (3) tick();
        check_eq("rst wr",       WR_DATA,          1'b0);
        check_eq("rst freq",     MEM_DDS_freq,     48'hFFFF_FFFF_FFFF);
        check_eq("rst tstart",   MEM_TIME_START,   ONES);
        check_eq("rst type",     MEM_TYPE_impulse, 2'b11);
        check_eq("rst level",    LEVEL,            5'd0);
        check_eq("rst empty",    EMPTY,            1'b1);
        check_eq("rst full",     FULL,             1'b0);
        check_eq("rst overflow", OVERFLOW,         1'b0);
        check_eq("rst dropcnt",  DROP_CNT,         16'd0);
        check_eq("rst loaded",   LOADED,           1'b0);
        RESET = 1'b0;
        tick();

        a = mk_cmd(T0 + 64'd1000, 16'd3, 32'd100, 32'd7);
        write_cmd(a);
        check_eq("A level after commit", LEVEL, 5'd1);
        expect_issue("A", a);
        check_eq("A level after issue", LEVEL, 5'd0);

        for (int k = 0; k < 3; k++) begin
            q[k] = mk_cmd(T0 + 64'd5000 + 64'(k), 16'(10 + k), 32'(1000 + k), 32'(100 + k));
            write_cmd(q[k]);
        end
        check_eq("queue3 level", LEVEL, 5'd3);
        for (int k = 0; k < 3; k++) begin
            req_pulse(cnt, first, b2);
            check_eq($sformatf("pulse%0d count", k), 64'(cnt),   64'd1);
            check_eq($sformatf("pulse%0d delay", k), 64'(first), 64'd4);
            check_eq($sformatf("pulse%0d order", k), b2, q[k].tblank2);
        end
        check_eq("queue3 empty", EMPTY, 1'b1);
        req_pulse(cnt, first, b2);
        check_eq("accept last no wr", 64'(cnt), 64'd0);
        check_eq("accept last loaded", LOADED, 1'b0);

        e = mk_cmd(T0 + 64'd10, 16'd20, 32'd11, 32'd200);
        write_cmd(e);
        tick(); tick();
        check_eq("late drop early", DROP, 1'b0);
        tick();
        check_eq("late drop",     DROP,        1'b1);
        check_eq("late no wr",    WR_DATA,     1'b0);
        check_eq("late dropcnt",  DROP_CNT,    16'd1);
        check_eq("late mem hold", MEM_Tblank2, q[2].tblank2);
        tick();
        check_eq("drop one-cycle", DROP, 1'b0);

        f = mk_cmd(T0 + 64'd64, 16'd21, 32'd12, 32'd201);
        write_cmd(f);
        expect_issue("F lead boundary", f);
        check_eq("F dropcnt kept", DROP_CNT, 16'd1);
        req_pulse(cnt, first, b2);
        check_eq("accept F no wr", 64'(cnt), 64'd0);

        h = mk_cmd(T0 + 64'd100000, 16'd30, 32'd13, 32'd300);
        write_cmd(h);
        expect_issue("H", h);
        for (int k = 1; k <= 17; k++) begin
            host_wr(4'd11, 32'h1000 + 32'(k));
            if (k == 15) check_eq("fill level15", LEVEL, 5'd15);
            if (k == 16) begin
                check_eq("fill level16",    LEVEL,    5'd16);
                check_eq("fill full",       FULL,     1'b1);
                check_eq("no overflow yet", OVERFLOW, 1'b0);
            end
        end
        check_eq("overflow set",    OVERFLOW, 1'b1);
        check_eq("overflow level",  LEVEL,    5'd16);

        FLUSH = 1'b1; HOST_ADDR = 4'd11; HOST_WDATA = 32'h5555; HOST_WE = 1'b1;
        tick();
        FLUSH = 1'b0; HOST_WE = 1'b0;
        check_eq("flush wr",       WR_DATA,        1'b1);
        check_eq("flush tstart",   MEM_TIME_START, ONES);
        check_eq("flush freq",     MEM_DDS_freq,   h.freq);
        check_eq("flush tb2",      MEM_Tblank2,    h.tblank2);
        check_eq("flush level",    LEVEL,          5'd0);
        check_eq("flush empty",    EMPTY,          1'b1);
        check_eq("flush loaded",   LOADED,         1'b0);
        check_eq("flush overflow", OVERFLOW,       1'b0);
        check_eq("flush dropcnt",  DROP_CNT,       16'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (WR_DATA) cnt++;
        end
        check_eq("flush quiet", 64'(cnt), 64'd0);

        SYS_TIME_UPDATE_OK = 1'b0;
        ic = mk_cmd(T0 + 64'd2000, 16'd40, 32'd14, 32'd400);
        write_cmd(ic);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (WR_DATA) cnt++;
        end
        check_eq("unsynced no wr",  64'(cnt), 64'd0);
        check_eq("unsynced popped", LEVEL,    5'd0);
        SYS_TIME_UPDATE_OK = 1'b1;
        tick();
        check_eq("synced wr", WR_DATA, 1'b1);
        check_mem("synced", ic);

        #3 RESET = 1'b1;
        #1;
        check_eq("rst mid wr",     WR_DATA,        1'b0);
        check_eq("rst mid loaded", LOADED,         1'b0);
        check_eq("rst mid tstart", MEM_TIME_START, ONES);
        check_eq("rst mid n",      MEM_N_impuls,   16'hFFFF);
        check_eq("rst mid empty",  EMPTY,          1'b1);
        #5 RESET = 1'b0;
        tick(); tick();
        check_eq("post rst wr", WR_DATA, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
